// File: rtl/cska_operand_pipe.sv
// rtl/cska_operand_pipe.sv - two-stage operand/result pipeline around the CSkipA_17bit adder
// S1 holds operands and drives the adder; S2 captures sum/cout. Also keeps an accumulator and a carry counter.
module cska_operand_pipe #(
   parameter int WIDTH = 17,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   input  logic [1:0]       i_mode,
   output logic [WIDTH-1:0] o_add_term1,
   output logic [WIDTH-1:0] o_add_term2,
   input  logic [WIDTH-1:0] i_sum,
   input  logic             i_cout,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic [WIDTH-1:0] o_acc,
   input  logic             i_cnt_clr,
   output logic [CNT_W-1:0] o_carry_cnt
);

   localparam logic [1:0] MODE_ACC  = 2'b01;
   localparam logic [1:0] MODE_LOAD = 2'b10;

   logic             s1_valid_q, s1_valid_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [1:0]       s1_mode_q, s1_mode_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic s1_adv;
   logic accept;

   assign s1_adv  = s1_valid_q & (~s2_valid_q | i_ready);
   assign o_ready = ~s1_valid_q | s1_adv;
   assign accept  = i_valid & o_ready;

   // Adder terms come only from S1 registers, so upstream inputs never reach the adder directly.
   always_comb begin
      o_add_term1 = s1_a_q;
      o_add_term2 = s1_b_q;
      case (s1_mode_q)
         MODE_ACC:  o_add_term1 = acc_q;
         MODE_LOAD: o_add_term1 = '0;
         default:   o_add_term1 = s1_a_q;
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_mode_d  = s1_mode_q;
      s2_valid_d = s2_valid_q;
      acc_d      = acc_q;
      result_d   = result_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = i_op_a;
         s1_b_d     = i_op_b;
         s1_mode_d  = i_mode;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         result_d   = i_sum;
         carry_d    = i_cout;
         s2_valid_d = 1'b1;
         // Updating acc on the advance edge lets the next accumulate in S1 see it without a stall.
         if (s1_mode_q == MODE_ACC || s1_mode_q == MODE_LOAD)
            acc_d = i_sum;
      end else if (s2_valid_q & i_ready) begin
         s2_valid_d = 1'b0;
      end

      if (i_cnt_clr)
         cnt_d = '0;
      else if (s1_adv && i_cout && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_mode_q  <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_mode_q  <= s1_mode_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
      end
   end

   assign o_valid     = s2_valid_q;
   assign o_result    = result_q;
   assign o_carry     = carry_q;
   assign o_acc       = acc_q;
   assign o_carry_cnt = cnt_q;

endmodule

// File: tb/tb_cska_operand_pipe.sv
// tb/tb_cska_operand_pipe.sv - bench for cska_operand_pipe with behavioural adder and reference model
module tb_cska_operand_pipe;
   localparam int W = 17;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic [1:0]    mode = 2'b00;
   logic [W-1:0]  term1, term2;
   logic [W-1:0]  sum;
   logic          cout;
   logic          o_valid;
   logic          i_ready = 1'b1;
   logic [W-1:0]  o_result;
   logic          o_carry;
   logic [W-1:0]  o_acc;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] o_carry_cnt;

   int checks = 0;
   int failures = 0;

   logic [W:0] exp_q[$];
   logic [W-1:0] mdl_acc = '0;
   int mdl_cnt = 0;
   bit rnd_stop = 1'b0;

   always #5 clk = ~clk;

   // Stand-in for the carry-skip adder netlist: cin tied to 0.
   assign {cout, sum} = {1'b0, term1} + {1'b0, term2};

   cska_operand_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_op_a(op_a), .i_op_b(op_b), .i_mode(mode),
      .o_add_term1(term1), .o_add_term2(term2), .i_sum(sum), .i_cout(cout),
      .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_carry(o_carry),
      .o_acc(o_acc), .i_cnt_clr(cnt_clr), .o_carry_cnt(o_carry_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Each accepted operation is evaluated in order from the modes' arithmetic definitions.
   task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
      logic [W:0] full;
      case (m)
         2'b01:   full = {1'b0, mdl_acc} + {1'b0, b};
         2'b10:   full = {1'b0, b};
         default: full = {1'b0, a} + {1'b0, b};
      endcase
      exp_q.push_back(full);
      if (m == 2'b01 || m == 2'b10) mdl_acc = full[W-1:0];
      if (full[W]) mdl_cnt = (mdl_cnt >= 255) ? 255 : mdl_cnt + 1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
      int n;
      i_valid = 1'b1; op_a = a; op_b = b; mode = m;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (o_ready) break;
      end
      if (n == 100) chk("accept_timeout", 32'd0, 32'd1);
      model_push(a, b, m);
      @(posedge clk); #1;
      i_valid = 1'b0; op_a = 'x; op_b = 'x; mode = 'x;
   endtask

   task automatic drain();
      int n;
      for (n = 0; n < 200; n++) begin
         @(posedge clk); #2;
         if (exp_q.size() == 0 && !o_valid) break;
      end
      chk("drain_left", exp_q.size(), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         if (exp_q.size() == 0) chk("unexpected_result", {14'd0, o_carry, o_result}, 32'hFFFF_FFFF);
         else chk("result", {14'd0, o_carry, o_result}, {14'd0, exp_q.pop_front()});
      end
   end

   initial begin
      #12;
      chk("rst_valid", o_valid, 0);
      chk("rst_terms", {term1, term2} != 0, 0);
      chk("rst_acc", o_acc, 0);
      chk("rst_cnt", o_carry_cnt, 0);
      chk("rst_result", {o_carry, o_result}, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", o_ready, 1);

      // Single add and latency
      @(posedge clk); #1;
      send(17'h0FFFF, 17'h00001, 2'b00);
      chk("lat_valid_k", o_valid, 0);
      chk("lat_term1", term1, 17'h0FFFF);
      @(negedge clk);
      chk("lat_valid_half", o_valid, 0);
      @(negedge clk);
      chk("lat_valid_k1", o_valid, 1);
      chk("lat_result", o_result, 17'h10000);
      drain();
      chk("add_cnt", o_carry_cnt, 0);

      // Overflow and saturation
      send(17'h1FFFF, 17'h00001, 2'b00);
      drain();
      chk("ovf_carry", o_carry, 1);
      chk("ovf_cnt", o_carry_cnt, 1);
      for (int i = 0; i < 300; i++) send(17'h1FFFF, 17'h00001, 2'b00);
      drain();
      chk("sat_cnt", o_carry_cnt, 255);
      send(17'h1FFFF, 17'h00001, 2'b00);
      cnt_clr = 1'b1;
      @(posedge clk); #1; cnt_clr = 1'b0;
      mdl_cnt = 0;
      drain();
      chk("clr_prio_cnt", o_carry_cnt, 0);

      // Accumulate streaming back-to-back
      send(17'd5, 17'd5, 2'b10);
      send('x, 17'd3, 2'b01);
      send('x, 17'h1FFFF, 2'b01);
      drain();
      chk("acc_final", o_acc, 17'd7);
      chk("acc_carry", o_carry, 1);

      // Mode 11 behaves as add, acc untouched
      send(17'h00010, 17'h00020, 2'b11);
      drain();
      chk("m11_result", o_result, 17'h00030);
      chk("m11_acc", o_acc, 17'd7);

      // Backpressure: 2 in flight, third held, no bubble on release
      i_ready = 1'b0;
      send(17'd1, 17'd1, 2'b00);
      send(17'd2, 17'd2, 2'b00);
      i_valid = 1'b1; op_a = 17'd3; op_b = 17'd3; mode = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_ready_low", o_ready, 0);
         chk("bp_hold", {o_valid, o_result}, {1'b1, 17'd2});
      end
      @(posedge clk); #1; i_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", o_ready, 1);
      model_push(17'd3, 17'd3, 2'b00);
      @(posedge clk); #1; i_valid = 1'b0;
      drain();

      // Randomized traffic with random backpressure
      fork
         while (!rnd_stop) begin
            @(posedge clk); #1;
            i_ready = ($urandom_range(0, 3) != 0);
         end
      join_none
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         send($urandom(), $urandom(), 2'($urandom_range(0, 3)));
      end
      rnd_stop = 1'b1;
      @(posedge clk); #2; i_ready = 1'b1;
      drain();
      chk("rnd_acc", o_acc, mdl_acc);
      chk("rnd_cnt", o_carry_cnt, mdl_cnt);

      // Mid-operation reset with S1 and S2 full
      i_ready = 1'b0;
      send(17'h1FFFF, 17'h00001, 2'b00);
      send(17'd9, 17'd9, 2'b10);
      #3; rst_n = 1'b0; #1;
      chk("mrst_valid", o_valid, 0);
      chk("mrst_acc", o_acc, 0);
      chk("mrst_cnt", o_carry_cnt, 0);
      chk("mrst_terms", {term1, term2} != 0, 0);
      exp_q.delete(); mdl_acc = '0; mdl_cnt = 0;
      i_ready = 1'b1;
      @(posedge clk); #1; rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mrst_no_stale", o_valid, 0);
         chk("mrst_ready", o_ready, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
